// File: rtl/player_pkg.sv
// Shared types and constants for the player speed-boost logic.
// Holds the speed level type, the controller state enum, the highest level
// index and the level-to-speed table shared with the movement block.
package player_pkg;

    localparam int unsigned FRAMES_W        = 9;
    localparam int unsigned SPEED_W         = 8;
    localparam int unsigned MAX_SPEED_LEVEL = 2;

    typedef logic [1:0] speed_level_t;

    typedef enum logic [1:0] {
        IDLE_ST  = 2'd0,
        BASE_ST  = 2'd1,
        BOOST_ST = 2'd2
    } state_t;

    // Sub-pixels per frame, indexed by speed level: {160, 112, 64}
    localparam logic [2:0][SPEED_W-1:0] SPEED_TABLE = {8'd160, 8'd112, 8'd64};

    // Movement speed for a given level; out-of-range levels clamp to the top entry
    function automatic logic [SPEED_W-1:0] speed_of(input speed_level_t lvl);
        if (lvl > 2'd2) begin
            return SPEED_TABLE[2];
        end
        return SPEED_TABLE[lvl];
    endfunction

endpackage : player_pkg

// File: rtl/player_speed_ctrl_if.sv
// Game-side bus to the speed controller.
// master: game/frame logic driving frame pulses and events, reading speed.
// slave : player_speed_ctrl.
//   startOfFrame   one-cycle pulse per frame
//   game_on        high while a round runs
//   powerup_pickup one-cycle pulse on speed powerup collection
//   player_hit     one-cycle pulse when the player is killed
//   speed_level    current level index (0..MAX_LEVEL)
//   frames_left    frames remaining at the current boost level
//   speed_warning  boost about to expire
interface player_speed_ctrl_if;
    import player_pkg::*;

    logic                startOfFrame;
    logic                game_on;
    logic                powerup_pickup;
    logic                player_hit;
    speed_level_t        speed_level;
    logic [FRAMES_W-1:0] frames_left;
    logic                speed_warning;

    modport master (
        output startOfFrame, game_on, powerup_pickup, player_hit,
        input  speed_level, frames_left, speed_warning
    );

    modport slave (
        input  startOfFrame, game_on, powerup_pickup, player_hit,
        output speed_level, frames_left, speed_warning
    );

endinterface : player_speed_ctrl_if

// File: rtl/frame_timer.sv
// Loadable frame down-counter backing frames_left.
//   clk, resetN   clock, async active-low reset
//   clear         force count to 0 (highest priority)
//   load          load load_value
//   dec_on_sof    decrement on sof, saturating at 0
//   sof           frame pulse
//   count         registered count
//   count_next_c  value count takes at the next edge
//   zero_c        count == 0
module frame_timer
    import player_pkg::*;
(
    input  logic                clk,
    input  logic                resetN,
    input  logic                clear,
    input  logic                load,
    input  logic [FRAMES_W-1:0] load_value,
    input  logic                dec_on_sof,
    input  logic                sof,
    output logic [FRAMES_W-1:0] count,
    output logic [FRAMES_W-1:0] count_next_c,
    output logic                zero_c
);

    assign zero_c = (count == '0);

    // Next count: clear > load > saturating decrement
    always_comb begin
        count_next_c = count;
        if (clear) begin
            count_next_c = '0;
        end else if (load) begin
            count_next_c = load_value;
        end else if (dec_on_sof && sof && !zero_c) begin
            count_next_c = count - FRAMES_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            count <= '0;
        end else begin
            count <= count_next_c;
        end
    end

endmodule : frame_timer

// File: rtl/player_speed_ctrl.sv
// Player speed-boost controller: powerups raise the speed level for a fixed
// number of frames each; levels step down one at a time on expiry.
//   clk     system clock
//   resetN  async active-low reset
//   bus     player_speed_ctrl_if.slave (frame/event inputs, speed outputs)
// Optional feature macro: SPEED_WARN_EN enables the blinking expiry warning;
// without it speed_warning is tied low.
module player_speed_ctrl
    import player_pkg::*;
#(
    parameter int unsigned DURATION_FRAMES = 300,
    parameter int unsigned WARN_FRAMES     = 60,
    parameter int unsigned MAX_LEVEL       = MAX_SPEED_LEVEL
) (
    input  logic                clk,
    input  logic                resetN,
    player_speed_ctrl_if.slave  bus
);

    localparam logic [FRAMES_W-1:0] DURATION = FRAMES_W'(DURATION_FRAMES);
    localparam speed_level_t        MAX_LVL  = speed_level_t'(MAX_LEVEL);

    state_t              state, state_n;
    speed_level_t        level, level_n;
    logic                t_clear, t_load, t_dec;
    logic [FRAMES_W-1:0] frames, frames_next;
    logic                frames_zero;
    logic                expire;

    frame_timer u_timer (
        .clk          (clk),
        .resetN       (resetN),
        .clear        (t_clear),
        .load         (t_load),
        .load_value   (DURATION),
        .dec_on_sof   (t_dec),
        .sof          (bus.startOfFrame),
        .count        (frames),
        .count_next_c (frames_next),
        .zero_c       (frames_zero)
    );

    // Last frame of the current level (zero included as a guard)
    assign expire = bus.startOfFrame && (frames_zero || (frames == FRAMES_W'(1)));

    // State and level registers
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state <= IDLE_ST;
            level <= '0;
        end else begin
            state <= state_n;
            level <= level_n;
        end
    end

    // Next state, next level and timer controls; event priority is
    // game_on low > player_hit > pickup > startOfFrame
    always_comb begin
        state_n = state;
        level_n = level;
        t_clear = 1'b0;
        t_load  = 1'b0;
        t_dec   = 1'b0;

        if (!bus.game_on) begin
            state_n = IDLE_ST;
            level_n = '0;
            t_clear = 1'b1;
        end else begin
            unique case (state)
                IDLE_ST: begin
                    state_n = BASE_ST;
                    level_n = '0;
                    t_clear = 1'b1;
                end
                BASE_ST: begin
                    if (bus.player_hit) begin
                        level_n = '0;
                        t_clear = 1'b1;
                    end else if (bus.powerup_pickup) begin
                        state_n = BOOST_ST;
                        level_n = speed_level_t'(1);
                        t_load  = 1'b1;
                    end else begin
                        level_n = '0;
                        t_clear = 1'b1;
                    end
                end
                BOOST_ST: begin
                    if (bus.player_hit) begin
                        state_n = BASE_ST;
                        level_n = '0;
                        t_clear = 1'b1;
                    end else if (bus.powerup_pickup) begin
                        level_n = (level >= MAX_LVL) ? MAX_LVL : level + speed_level_t'(1);
                        t_load  = 1'b1;
                    end else if (expire) begin
                        if (level > speed_level_t'(1)) begin
                            level_n = level - speed_level_t'(1);
                            t_load  = 1'b1;
                        end else begin
                            state_n = BASE_ST;
                            level_n = '0;
                            t_clear = 1'b1;
                        end
                    end else begin
                        t_dec = 1'b1;
                    end
                end
                default: begin
                    state_n = IDLE_ST;
                    level_n = '0;
                    t_clear = 1'b1;
                end
            endcase
        end
    end

    assign bus.speed_level = level;
    assign bus.frames_left = frames;

`ifdef SPEED_WARN_EN
    localparam logic [FRAMES_W-1:0] WARN_LIM = FRAMES_W'(WARN_FRAMES);

    logic       warn_q;
    logic       win_q;
    logic [1:0] blink;
    logic       win_n;

    // Window is judged on next-cycle values so warning aligns with frames_left
    assign win_n = (state_n == BOOST_ST) && (frames_next <= WARN_LIM);

    // Starts at 1 on window entry, then toggles every 4th frame pulse
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            warn_q <= 1'b0;
            win_q  <= 1'b0;
            blink  <= '0;
        end else if (!win_n) begin
            warn_q <= 1'b0;
            win_q  <= 1'b0;
            blink  <= '0;
        end else if (!win_q) begin
            warn_q <= 1'b1;
            win_q  <= 1'b1;
            blink  <= '0;
        end else if (bus.startOfFrame) begin
            if (blink == 2'd3) begin
                blink  <= '0;
                warn_q <= ~warn_q;
            end else begin
                blink <= blink + 2'd1;
            end
        end
    end

    assign bus.speed_warning = warn_q;
`else
    logic unused_warn_cfg;
    assign unused_warn_cfg   = ^{FRAMES_W'(WARN_FRAMES)};
    assign bus.speed_warning = 1'b0;
`endif

endmodule : player_speed_ctrl

// File: tb/tb_player_speed_ctrl.sv
// Self-checking bench for player_speed_ctrl: a directed vector table for
// single-cycle behaviour, then hand-written long boost sequences.
module tb_player_speed_ctrl;

    localparam int DUR  = 300;
    localparam int WARN = 60;

    logic clk;
    logic resetN;
    int   checks;
    int   errors;

    player_speed_ctrl_if bus();

    player_speed_ctrl dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       g;
        logic       p;
        logic       h;
        logic       s;
        logic [1:0] lvl;
        logic [8:0] fl;
    } vec_t;

    vec_t vecs[17];

    function automatic vec_t mk(input logic g, input logic p, input logic h, input logic s,
                                input logic [1:0] lvl, input int fl);
        vec_t v;
        v.g = g; v.p = p; v.h = h; v.s = s; v.lvl = lvl; v.fl = 9'(fl);
        return v;
    endfunction

    // Reference warning for an uninterrupted countdown from DUR
    function automatic logic exp_warn(input int fl);
`ifdef SPEED_WARN_EN
        if (fl != 0 && fl <= WARN) return ((((WARN - fl) / 4) % 2) == 0);
        return 1'b0;
`else
        return 1'b0;
`endif
    endfunction

    task automatic check(input string name, input logic [1:0] lvl, input int fl, input logic w);
        checks++;
        if (bus.speed_level !== lvl || bus.frames_left !== 9'(fl) || bus.speed_warning !== w) begin
            errors++;
            $display("FAIL %s: level=%0d frames_left=%0d warning=%0b, expected level=%0d frames_left=%0d warning=%0b",
                     name, bus.speed_level, bus.frames_left, bus.speed_warning, lvl, fl, w);
        end
    endtask

    // Apply one cycle of inputs at negedge; results sampled at the next negedge
    task automatic drive(input logic g, input logic p, input logic h, input logic s);
        bus.game_on        = g;
        bus.powerup_pickup = p;
        bus.player_hit     = h;
        bus.startOfFrame   = s;
        @(negedge clk);
        bus.powerup_pickup = 1'b0;
        bus.player_hit     = 1'b0;
        bus.startOfFrame   = 1'b0;
    endtask

    // One frame: sof cycle then an idle cycle
    task automatic frame();
        drive(1'b1, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic idle();
        drive(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    // n uninterrupted frames at a fixed level starting from start_fl
    task automatic run_boost(input string name, input int n, input logic [1:0] lvl, input int start_fl);
        for (int i = 1; i <= n; i++) begin
            frame();
            check(name, lvl, start_fl - i, exp_warn(start_fl - i));
            idle();
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        resetN = 1'b0;
        bus.game_on        = 1'b0;
        bus.powerup_pickup = 1'b0;
        bus.player_hit     = 1'b0;
        bus.startOfFrame   = 1'b0;

        vecs[0]  = mk(0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(0, 1, 0, 0, 0, 0);
        vecs[2]  = mk(1, 1, 0, 0, 0, 0);
        vecs[3]  = mk(1, 0, 0, 1, 0, 0);
        vecs[4]  = mk(1, 1, 0, 0, 1, 300);
        vecs[5]  = mk(1, 0, 0, 1, 1, 299);
        vecs[6]  = mk(1, 0, 0, 1, 1, 298);
        vecs[7]  = mk(1, 1, 0, 1, 2, 300);
        vecs[8]  = mk(1, 1, 0, 0, 2, 300);
        vecs[9]  = mk(1, 0, 0, 1, 2, 299);
        vecs[10] = mk(1, 1, 1, 1, 0, 0);
        vecs[11] = mk(1, 0, 0, 1, 0, 0);
        vecs[12] = mk(1, 1, 0, 0, 1, 300);
        vecs[13] = mk(0, 1, 0, 0, 0, 0);
        vecs[14] = mk(1, 1, 0, 0, 0, 0);
        vecs[15] = mk(1, 1, 0, 0, 1, 300);
        vecs[16] = mk(1, 0, 1, 0, 0, 0);

        repeat (2) @(negedge clk);
        check("reset", 2'd0, 0, 1'b0);
        resetN = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].g, vecs[i].p, vecs[i].h, vecs[i].s);
            check($sformatf("vec%0d", i), vecs[i].lvl, int'(vecs[i].fl), 1'b0);
        end

        // Single pickup, full 300-frame countdown to expiry
        drive(1, 1, 0, 0);
        check("a_pickup", 2'd1, DUR, 1'b0);
        run_boost("a_count", DUR - 1, 2'd1, DUR);
        frame();
        check("a_expire", 2'd0, 0, 1'b0);
        idle();
        frame();
        check("a_base_hold", 2'd0, 0, 1'b0);
        idle();

        // Pickups 10 frames apart: levels 1, 2, 2 with reloads
        drive(1, 1, 0, 0);
        check("b_pick1", 2'd1, DUR, 1'b0);
        run_boost("b_run1", 10, 2'd1, DUR);
        drive(1, 1, 0, 0);
        check("b_pick2", 2'd2, DUR, 1'b0);
        run_boost("b_run2", 10, 2'd2, DUR);
        drive(1, 1, 0, 0);
        check("b_pick3", 2'd2, DUR, 1'b0);

        // Level 2 steps down to 1, then to 0
        run_boost("c_run2", DUR - 1, 2'd2, DUR);
        frame();
        check("c_expire21", 2'd1, DUR, 1'b0);
        idle();
        run_boost("c_run1", DUR - 1, 2'd1, DUR);
        frame();
        check("c_expire10", 2'd0, 0, 1'b0);
        idle();

        // Pickup coincident with the expiring frame
        drive(1, 1, 0, 0);
        check("d_pickup", 2'd1, DUR, 1'b0);
        run_boost("d_run", DUR - 1, 2'd1, DUR);
        drive(1, 1, 0, 1);
        check("d_pick_vs_expire", 2'd2, DUR, 1'b0);
        run_boost("d_run2", 5, 2'd2, DUR);
        drive(1, 1, 1, 1);
        check("d_hit_priority", 2'd0, 0, 1'b0);
        frame();
        check("d_after_hit", 2'd0, 0, 1'b0);

        // Into the warning window, then game_on drops mid-boost
        drive(1, 1, 0, 0);
        check("e_pickup", 2'd1, DUR, 1'b0);
        run_boost("e_run", 250, 2'd1, DUR);
        drive(0, 1, 0, 1);
        check("e_game_off", 2'd0, 0, 1'b0);
        drive(1, 1, 0, 0);
        check("e_idle_exit", 2'd0, 0, 1'b0);

        // Asynchronous reset mid-boost discards the boost
        drive(1, 1, 0, 0);
        check("r_pickup", 2'd1, DUR, 1'b0);
        run_boost("r_run", 3, 2'd1, DUR);
        resetN = 1'b0;
        #1;
        check("r_async", 2'd0, 0, 1'b0);
        @(negedge clk);
        resetN = 1'b1;
        drive(1, 1, 0, 0);
        check("r_idle_wait", 2'd0, 0, 1'b0);
        drive(1, 1, 0, 0);
        check("r_pickup2", 2'd1, DUR, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_player_speed_ctrl
